// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Elastic pipeline-stage register for the packed WB bundle (data, write address,
//   enables, func3). Valid/ready handshake on both sides, a two-entry skid buffer
//   (MAIN drives the output, SKID holds the overflow entry), synchronous flush and
//   a saturating stall-cycle counter.
//
// Ports
//   CLK        in   1       rising-edge clock
//   RST_N      in   1       synchronous reset, active low (priority over everything)
//   FLUSH      in   1       synchronous kill of all held entries
//   IN_VALID   in   1       upstream payload valid
//   IN_READY   out  1       stage can accept a payload (decoded from state flops only)
//   IN_DATA    in   DATA_W  upstream payload
//   OUT_VALID  out  1       OUT_DATA holds a live payload
//   OUT_READY  in   1       downstream accepts this cycle
//   OUT_DATA   out  DATA_W  payload to downstream (MAIN register)
//   OCCUPANCY  out  2       held entries: 0, 1 or 2
//   STALL_CNT  out  CNT_W   cycles with OUT_VALID=1 and OUT_READY=0, saturating
module pipe_skid_stage #(
    parameter int unsigned DATA_W         = 74,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY,
    output logic [CNT_W-1:0]  STALL_CNT
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   main_q;
    logic [DATA_W-1:0]   skid_q;
    logic [CNT_W-1:0]    stall_q;
    logic                in_fire;
    logic                out_fire;

    // Handshake outputs decode state flops only, so IN_READY has no path from OUT_READY.
    assign OUT_VALID = (state_q != StEmpty);
    assign IN_READY  = (state_q != StFull);
    assign OCCUPANCY = state_q;
    assign OUT_DATA  = main_q;
    assign STALL_CNT = stall_q;

    assign in_fire  = IN_VALID & IN_READY;
    assign out_fire = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            // Counter keeps running through FLUSH; saturates instead of wrapping.
            if (OUT_VALID && !OUT_READY && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end

            if (FLUSH) begin
                // Same-cycle IN_DATA is dropped along with everything held.
                state_q <= StEmpty;
                if (CLEAR_ON_FLUSH) begin
                    main_q <= '0;
                    skid_q <= '0;
                end
            end else begin
                case (state_q)
                    StEmpty: begin
                        if (in_fire) begin
                            main_q  <= IN_DATA;
                            state_q <= StOne;
                        end
                    end
                    StOne: begin
                        if (in_fire && out_fire) begin
                            main_q <= IN_DATA;
                        end else if (in_fire) begin
                            skid_q  <= IN_DATA;
                            state_q <= StFull;
                        end else if (out_fire) begin
                            state_q <= StEmpty;
                        end
                    end
                    StFull: begin
                        // IN_READY is low here, so only a pop can happen.
                        if (out_fire) begin
                            main_q  <= skid_q;
                            state_q <= StOne;
                        end
                    end
                    default: state_q <= StEmpty;
                endcase
            end
        end
    end

endmodule
